// File: rtl/cpld_spi_reg_slave_pkg.sv
// Shared address map and FSM encoding for the CPLD SPI register responder.
package cpld_spi_reg_slave_pkg;

  localparam logic [6:0] ADDR_ID          = 7'h00;
  localparam logic [6:0] ADDR_STATUS_BASE = 7'h01;
  localparam logic [6:0] ADDR_CTRL_BASE   = 7'h40;

  // Bit-counter values at the last header bit and at the last frame bit.
  localparam logic [3:0] BIT_LAST_HDR = 4'd7;
  localparam logic [3:0] BIT_LAST     = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/cpld_spi_reg_slave_sync.sv
// Synchroniser chain for one SPI pin, with rise/fall detection on the synchronised level.
module cpld_spi_reg_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Shift the pin through the chain and keep one extra copy for edge detection.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_q    = r_chain[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/cpld_spi_reg_slave.sv
// SPI mode-0 register responder: 16-bit frames {RnW, addr[6:0], data[7:0]},
// read-back of ID/status/control bytes, write commit into control bytes.
//
// state | meaning
// IDLE  | waiting for chip-select fall
// ADDR  | shifting in RnW + address (8 rising edges)
// LOAD  | selecting the byte to return, status snapshot taken here
// DATA  | shifting TX byte out on falls, write data in on rises
// DONE  | frame complete, extra SCLKs ignored until chip-select rises
module cpld_spi_reg_slave
  import cpld_spi_reg_slave_pkg::*;
#(
  parameter logic [7:0]            DEV_ID      = 8'hA5,
  parameter int                    NUM_STATUS  = 4,
  parameter int                    NUM_CTRL    = 4,
  parameter logic [8*NUM_CTRL-1:0] CTRL_RESET  = '0,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                    sysclk,
  input  logic                    reset_INV,
  input  logic                    spi_clk,
  input  logic                    spi_cs_INV,
  input  logic                    spi_mosi,
  output logic                    spi_miso,
  input  logic [8*NUM_STATUS-1:0] status_in,
  output logic [8*NUM_CTRL-1:0]   ctrl_out,
  output logic                    wr_strobe,
  output logic [6:0]              wr_addr,
  output logic                    frame_abort
);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_unused_edges;

  cpld_spi_reg_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .sysclk(sysclk), .reset_INV(reset_INV), .i_d(spi_clk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  // CS resets to the "selected" level so that releasing reset while the master
  // holds CS low does not look like a fresh CS fall; the frame must start over.
  cpld_spi_reg_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .sysclk(sysclk), .reset_INV(reset_INV), .i_d(spi_cs_INV),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  cpld_spi_reg_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .sysclk(sysclk), .reset_INV(reset_INV), .i_d(spi_mosi),
    .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  assign w_unused_edges = w_sclk_q ^ w_cs_rise ^ w_mosi_rise ^ w_mosi_fall;

  state_t                r_state, w_next_state;
  logic [3:0]            r_bit_cnt;
  logic [7:0]            r_shift, r_tx;
  logic                  r_rnw;
  logic [6:0]            r_addr;
  logic                  r_miso, r_commit_pend, r_wr_strobe, r_frame_abort;
  logic [6:0]            r_wr_addr;
  logic [8*NUM_CTRL-1:0] r_ctrl;
  logic                  w_abort, w_commit, w_ctrl_hit;
  logic [7:0]            w_tx_byte;

  // Address decode: byte to return and whether the address is a control byte.
  always_comb begin
    w_tx_byte  = 8'h00;
    w_ctrl_hit = 1'b0;
    if (r_addr == ADDR_ID) w_tx_byte = DEV_ID;
    for (int k = 0; k < NUM_STATUS; k++)
      if (r_addr == ADDR_STATUS_BASE + 7'(k)) w_tx_byte = status_in[8*k +: 8];
    for (int k = 0; k < NUM_CTRL; k++)
      if (r_addr == ADDR_CTRL_BASE + 7'(k)) begin
        w_tx_byte  = r_ctrl[8*k +: 8];
        w_ctrl_hit = 1'b1;
      end
  end

  // State register.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // Next state; the 16th rising edge wins over a simultaneous CS rise.
  always_comb begin
    w_next_state = r_state;
    w_abort      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_cs_fall) w_next_state = ST_ADDR;
      ST_ADDR: begin
        if (w_cs_q) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_sclk_rise && r_bit_cnt == BIT_LAST_HDR) begin
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_cs_q) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_sclk_rise && r_bit_cnt == BIT_LAST) begin
          w_commit     = !r_rnw && w_ctrl_hit;
          w_next_state = ST_DONE;
        end else if (w_cs_q) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_DONE: if (w_cs_q) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame datapath: bit counting, shifting, TX load, MISO, commit and pulses.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_tx          <= '0;
      r_rnw         <= 1'b0;
      r_addr        <= '0;
      r_miso        <= 1'b0;
      r_commit_pend <= 1'b0;
      r_wr_strobe   <= 1'b0;
      r_wr_addr     <= '0;
      r_frame_abort <= 1'b0;
      r_ctrl        <= CTRL_RESET;
    end else begin
      r_frame_abort <= w_abort;
      r_commit_pend <= w_commit;
      r_wr_strobe   <= r_commit_pend;
      if (r_state == ST_IDLE && w_cs_fall) r_bit_cnt <= '0;
      if ((r_state == ST_ADDR || r_state == ST_DATA) && w_sclk_rise) begin
        r_shift <= {r_shift[6:0], w_mosi_q};
        if (r_bit_cnt != BIT_LAST) r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (r_state == ST_ADDR && w_sclk_rise && r_bit_cnt == BIT_LAST_HDR) begin
        r_rnw  <= r_shift[6];
        r_addr <= {r_shift[5:0], w_mosi_q};
      end
      if (r_state == ST_LOAD) r_tx <= w_tx_byte;
      if (w_next_state != ST_DATA) begin
        r_miso <= 1'b0;
      end else if (r_state == ST_DATA && w_sclk_fall) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
      if (r_commit_pend) begin
        r_wr_addr <= r_addr;
        for (int k = 0; k < NUM_CTRL; k++)
          if (r_addr == ADDR_CTRL_BASE + 7'(k)) r_ctrl[8*k +: 8] <= r_shift;
      end
    end
  end

  assign spi_miso    = r_miso;
  assign ctrl_out    = r_ctrl;
  assign wr_strobe   = r_wr_strobe;
  assign wr_addr     = r_wr_addr;
  assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_cpld_spi_reg_slave.sv
// Bench for cpld_spi_reg_slave: SPI master at sysclk/10 with a scoreboard for
// returned bytes and committed writes.
module tb_cpld_spi_reg_slave;

  logic        sysclk = 1'b0;
  logic        reset_INV = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_INV = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [31:0] status_in = 32'h0;
  logic [31:0] ctrl_out;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_abort;

  cpld_spi_reg_slave dut (
    .sysclk(sysclk), .reset_INV(reset_INV), .spi_clk(spi_clk),
    .spi_cs_INV(spi_cs_INV), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .status_in(status_in), .ctrl_out(ctrl_out), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .frame_abort(frame_abort));

  always #5 sysclk = ~sysclk;

  int          n_checks = 0, n_errors = 0;
  int          n_abort_seen = 0, n_abort_exp = 0;
  int          n_strobe_cyc = 0, n_wr_exp = 0;
  logic [7:0]  exp_miso[$];
  logic [14:0] exp_wr[$];
  logic [31:0] m_ctrl = 32'h0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_tx(input logic [6:0] a);
    int k;
    k = int'(a);
    if (k == 0) return 8'hA5;
    if (k >= 1 && k <= 4) return status_in[8*(k-1) +: 8];
    if (k >= 'h40 && k <= 'h43) return m_ctrl[8*(k-'h40) +: 8];
    return 8'h00;
  endfunction

  task automatic half_bit();
    repeat (5) @(negedge sysclk);
  endtask

  // Write commits and abort pulses as the DUT produces them.
  always @(negedge sysclk) begin
    if (reset_INV) begin
      if (frame_abort) n_abort_seen++;
      if (wr_strobe) begin
        n_strobe_cyc++;
        chk_val("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          logic [14:0] e;
          int k;
          e = exp_wr.pop_front();
          k = int'(e[14:8]) - 'h40;
          chk_val("wr_addr", 32'(wr_addr), 32'(e[14:8]));
          chk_val("ctrl_byte", 32'(ctrl_out[8*k +: 8]), 32'(e[7:0]));
        end
      end
    end
  end

  task automatic spi_frame(input logic rnw, input logic [6:0] addr, input logic [7:0] wdata,
                           input int nbits, input int chg_bit, input logic [31:0] chg_val);
    logic [15:0] word;
    logic [7:0]  rx;
    logic        is_wr;
    word  = {rnw, addr, wdata};
    rx    = 8'h00;
    is_wr = (nbits >= 16) && !rnw && (addr >= 7'h40) && (addr <= 7'h43);
    if (nbits >= 16) exp_miso.push_back(model_tx(addr));
    else n_abort_exp++;
    if (is_wr) begin
      exp_wr.push_back({addr, wdata});
      n_wr_exp++;
    end
    @(negedge sysclk);
    spi_cs_INV = 1'b0;
    half_bit();
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'b1;
      half_bit();
      spi_clk = 1'b1;
      if (i == chg_bit) status_in = chg_val;
      if (i >= 8 && i < 16) rx = {rx[6:0], spi_miso};
      half_bit();
      spi_clk = 1'b0;
    end
    half_bit();
    spi_cs_INV = 1'b1;
    repeat (10) @(negedge sysclk);
    if (nbits >= 16) chk_val("miso_byte", 32'(rx), 32'(exp_miso.pop_front()));
    if (is_wr) m_ctrl[8*(int'(addr)-'h40) +: 8] = wdata;
    chk_val("ctrl_out", ctrl_out, m_ctrl);
    chk_val("abort_cnt", 32'(n_abort_seen), 32'(n_abort_exp));
    chk_val("miso_idle", 32'(spi_miso), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge sysclk);
    chk_val("rst_miso", 32'(spi_miso), 32'd0);
    chk_val("rst_ctrl", ctrl_out, 32'h0);
    chk_val("rst_strobe", 32'(wr_strobe), 32'd0);
    chk_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk_val("rst_abort", 32'(frame_abort), 32'd0);
    reset_INV = 1'b1;
    repeat (5) @(negedge sysclk);

    spi_frame(1'b1, 7'h00, 8'h00, 16, -1, 32'h0);
    spi_frame(1'b0, 7'h41, 8'h3C, 16, -1, 32'h0);
    spi_frame(1'b1, 7'h41, 8'h00, 16, -1, 32'h0);

    status_in = 32'h1122_3396;
    spi_frame(1'b1, 7'h01, 8'h00, 16, 10, 32'h0);
    status_in = 32'hC35A_0FF0;
    spi_frame(1'b1, 7'h04, 8'h00, 16, -1, 32'h0);
    spi_frame(1'b1, 7'h05, 8'h00, 16, -1, 32'h0);

    spi_frame(1'b0, 7'h40, 8'hFF, 12, -1, 32'h0);

    spi_frame(1'b0, 7'h7F, 8'h55, 16, -1, 32'h0);
    spi_frame(1'b0, 7'h00, 8'h55, 16, -1, 32'h0);
    spi_frame(1'b1, 7'h7F, 8'h00, 16, -1, 32'h0);
    spi_frame(1'b0, 7'h43, 8'hA7, 16, -1, 32'h0);
    spi_frame(1'b1, 7'h43, 8'h00, 16, -1, 32'h0);
    spi_frame(1'b1, 7'h44, 8'h00, 16, -1, 32'h0);

    spi_frame(1'b0, 7'h42, 8'h5A, 20, -1, 32'h0);
    spi_frame(1'b1, 7'h42, 8'h00, 16, -1, 32'h0);

    // Reset in the middle of a write frame, then let the master finish clocking.
    @(negedge sysclk);
    spi_cs_INV = 1'b0;
    half_bit();
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        reset_INV = 1'b0;
        repeat (2) @(negedge sysclk);
        chk_val("midrst_miso", 32'(spi_miso), 32'd0);
        chk_val("midrst_ctrl", ctrl_out, 32'h0);
        chk_val("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk_val("midrst_abort", 32'(frame_abort), 32'd0);
        m_ctrl = 32'h0;
        reset_INV = 1'b1;
      end
      spi_mosi = i[0];
      half_bit();
      spi_clk = 1'b1;
      half_bit();
      spi_clk = 1'b0;
    end
    half_bit();
    spi_cs_INV = 1'b1;
    repeat (10) @(negedge sysclk);
    chk_val("post_rst_ctrl", ctrl_out, 32'h0);
    chk_val("post_rst_abort", 32'(n_abort_seen), 32'(n_abort_exp));

    spi_frame(1'b0, 7'h40, 8'h81, 16, -1, 32'h0);
    spi_frame(1'b1, 7'h40, 8'h00, 16, -1, 32'h0);

    repeat (10) @(negedge sysclk);
    chk_val("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk_val("strobe_cycles", 32'(n_strobe_cyc), 32'(n_wr_exp));
    chk_val("miso_queue_empty", 32'(exp_miso.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
